// File: rtl/acc_seq.sv
// acc_seq: pops a programmed number of FIFO products, sums them, and presents the result via valid/ready
module acc_seq #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 20,
    parameter int LEN_W  = 8
) (
    input  logic              Rclk,
    input  logic              rrst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic [DATA_W-1:0] Acc_i,
    input  logic              Rempty_i,
    output logic              ren_o,
    output logic [SUM_W-1:0]  Sum_o,
    output logic              Sum_valid,
    input  logic              Sum_ready,
    output logic              Ovf_o,
    output logic              Busy_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [LEN_W-1:0]   cnt, len_q;
    logic [SUM_W:0]     add;
    logic               last;

    assign add  = {1'b0, Sum_o} + {{(SUM_W-DATA_W+1){1'b0}}, Acc_i};
    assign last = (cnt + 1'b1) == len_q;

    // Pop strobe and next state; abort overrides any pop, including the final one
    always_comb begin
        ren_o    = 1'b0;
        state_nx = state;
        case (state)
            IDLE: state_nx = start ? ((len != '0) ? RUN : DONE) : IDLE;
            RUN: begin
                ren_o    = !Rempty_i && !abort && !rrst;
                state_nx = abort ? IDLE : (ren_o && last) ? DONE : RUN;
            end
            DONE: state_nx = Sum_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // State, job bookkeeping and registered outputs
    always_ff @(posedge Rclk) begin
        if (rrst) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            Sum_o     <= '0;
            Ovf_o     <= 1'b0;
            Sum_valid <= 1'b0;
            Busy_o    <= 1'b0;
        end else begin
            state     <= state_nx;
            Sum_valid <= state_nx == DONE;
            Busy_o    <= state_nx != IDLE;
            if (state == IDLE && start) begin
                len_q <= len;
                cnt   <= '0;
                Sum_o <= '0;
                Ovf_o <= 1'b0;
            end else if (ren_o) begin
                Sum_o <= add[SUM_W-1:0];
                Ovf_o <= Ovf_o | add[SUM_W];
                cnt   <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_acc_seq.sv
// tb_acc_seq: directed checks of acc_seq against a small FIFO model and hand-computed sums
module tb_acc_seq;
  logic        Rclk = 0;
  logic        rrst, start, start9, abort, Sum_ready, stall;
  logic [7:0]  len, Acc_i;
  logic        Rempty_i;
  logic        ren_o, Sum_valid, Ovf_o, Busy_o;
  logic [19:0] Sum_o;
  logic        ren9, Sum_valid9, Ovf9, Busy9;
  logic [8:0]  Sum9;
  logic [7:0]  mem [0:63];
  int          rd = 0, wr = 0, pops = 0, n_chk = 0, n_fail = 0;
  always #5 Rclk = ~Rclk;
  assign Rempty_i = (rd == wr) || stall;
  assign Acc_i    = mem[rd[5:0]];
  always @(posedge Rclk) begin
    if (ren_o || ren9) rd <= rd + 1;
    if (ren_o) pops++;
  end
  acc_seq dut (
    .Rclk(Rclk), .rrst(rrst), .start(start), .len(len), .abort(abort),
    .Acc_i(Acc_i), .Rempty_i(Rempty_i), .ren_o(ren_o), .Sum_o(Sum_o),
    .Sum_valid(Sum_valid), .Sum_ready(Sum_ready), .Ovf_o(Ovf_o), .Busy_o(Busy_o)
  );
  acc_seq #(.SUM_W(9)) dut9 (
    .Rclk(Rclk), .rrst(rrst), .start(start9), .len(len), .abort(abort),
    .Acc_i(Acc_i), .Rempty_i(Rempty_i), .ren_o(ren9), .Sum_o(Sum9),
    .Sum_valid(Sum_valid9), .Sum_ready(Sum_ready), .Ovf_o(Ovf9), .Busy_o(Busy9)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Rclk);
    #1;
  endtask
  task automatic push(input logic [7:0] v);
    mem[wr[5:0]] = v;
    wr++;
  endtask
  initial begin
    rrst = 1; start = 0; start9 = 0; abort = 0; Sum_ready = 0; stall = 0; len = 0;
    tick(); tick();
    chk("rst_ren", ren_o, 1'b0);
    chk("rst_sum", Sum_o, 20'd0);
    chk("rst_valid", Sum_valid, 1'b0);
    chk("rst_ovf", Ovf_o, 1'b0);
    chk("rst_busy", Busy_o, 1'b0);
    rrst = 0;
    push(3); push(5); push(7); push(9); pops = 0;
    start = 1; len = 4; tick(); start = 0;
    chk("t1_busy", Busy_o, 1'b1);
    chk("t1_ren", ren_o, 1'b1);
    tick(); tick(); tick();
    chk("t1_valid_early", Sum_valid, 1'b0);
    tick();
    chk("t1_valid", Sum_valid, 1'b1);
    chk("t1_sum", Sum_o, 20'd24);
    chk("t1_ovf", Ovf_o, 1'b0);
    chk("t1_pops", pops, 4);
    chk("t1_ren_done", ren_o, 1'b0);
    Sum_ready = 1; tick(); Sum_ready = 0;
    chk("t1_idle_busy", Busy_o, 1'b0);
    chk("t1_idle_valid", Sum_valid, 1'b0);
    push(10); push(20); push(30); pops = 0;
    start = 1; len = 3; tick(); start = 0;
    tick();
    stall = 1; #1;
    chk("t2_ren_stall1", ren_o, 1'b0);
    tick();
    chk("t2_ren_stall2", ren_o, 1'b0);
    chk("t2_sum_stall", Sum_o, 20'd10);
    chk("t2_pops_stall", pops, 1);
    tick(); stall = 0; #1;
    tick();
    chk("t2_valid_early", Sum_valid, 1'b0);
    tick();
    chk("t2_valid", Sum_valid, 1'b1);
    chk("t2_sum", Sum_o, 20'd60);
    chk("t2_pops", pops, 3);
    Sum_ready = 1; tick(); Sum_ready = 0;
    push(255); push(255); push(255);
    start9 = 1; len = 3; tick(); start9 = 0;
    tick(); tick(); tick();
    chk("t3_valid", Sum_valid9, 1'b1);
    chk("t3_sum", Sum9, 9'd253);
    chk("t3_ovf", Ovf9, 1'b1);
    chk("t3_main_idle", Busy_o, 1'b0);
    Sum_ready = 1; tick(); Sum_ready = 0;
    start9 = 1; len = 0; tick(); start9 = 0;
    chk("t3_ovf_clr", Ovf9, 1'b0);
    chk("t3_sum_clr", Sum9, 9'd0);
    Sum_ready = 1; tick(); Sum_ready = 0;
    pops = 0;
    start = 1; len = 0; tick(); start = 0;
    chk("t4_valid", Sum_valid, 1'b1);
    chk("t4_sum", Sum_o, 20'd0);
    chk("t4_ren", ren_o, 1'b0);
    tick();
    chk("t4_pops", pops, 0);
    Sum_ready = 1; tick(); Sum_ready = 0;
    push(1); push(2);
    start = 1; len = 2; tick(); start = 0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_sum", Sum_o, 20'd3);
      chk("t5_hold_valid", Sum_valid, 1'b1);
      tick();
    end
    push(4);
    Sum_ready = 1; start = 1; len = 5; tick(); Sum_ready = 0;
    chk("t5_hs_busy", Busy_o, 1'b0);
    chk("t5_hs_valid", Sum_valid, 1'b0);
    chk("t5_hs_sum", Sum_o, 20'd3);
    len = 1; tick(); start = 0;
    chk("t5_new_busy", Busy_o, 1'b1);
    chk("t5_new_sum_clr", Sum_o, 20'd0);
    tick();
    chk("t5_new_valid", Sum_valid, 1'b1);
    chk("t5_new_sum", Sum_o, 20'd4);
    Sum_ready = 1; tick(); Sum_ready = 0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    pops = 0;
    start = 1; len = 8; tick(); start = 0;
    tick(); tick(); tick();
    abort = 1; #1;
    chk("t6_ren_abort", ren_o, 1'b0);
    tick(); abort = 0;
    chk("t6_busy", Busy_o, 1'b0);
    chk("t6_valid", Sum_valid, 1'b0);
    chk("t6_sum", Sum_o, 20'd6);
    tick(); tick();
    chk("t6_pops", pops, 3);
    chk("t6_valid_later", Sum_valid, 1'b0);
    start = 1; len = 4; tick(); start = 0;
    tick();
    chk("t7_sum_mid", Sum_o, 20'd4);
    rrst = 1; #1;
    chk("t7_ren_rst", ren_o, 1'b0);
    tick();
    chk("t7_sum", Sum_o, 20'd0);
    chk("t7_busy", Busy_o, 1'b0);
    chk("t7_valid", Sum_valid, 1'b0);
    chk("t7_ovf", Ovf_o, 1'b0);
    rrst = 0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
